// File: rtl/jtframe_8751_xbridge.sv
// Bridges the 8751 MCU external bus and the main CPU onto one shared byte RAM.
// Optional MCU<->main mailbox is compiled in with JTFRAME_8751_MBOX_EN.
module jtframe_8751_xbridge #(
  parameter int          AW        = 10,
  parameter logic [15:0] MBOX_ADDR = 16'hFFFF
) (
  input  logic          rst,
  input  logic          clk,
  input  logic [15:0]   x_addr,
  input  logic [7:0]    x_dout,
  input  logic          x_wr,
  input  logic          x_acc,
  output logic [7:0]    x_din,
  input  logic [AW-1:0] main_addr,
  input  logic [7:0]    main_dout,
  input  logic          main_we,
  input  logic          main_cs,
  input  logic          main_mbox,
  output logic [7:0]    main_din,
  output logic          main_ok,
  output logic          mcu_intn,
  output logic          main_irq
);

  typedef enum logic [1:0] {
    IDLE, MCU_ACC, MAIN_ACC, MAIN_DONE
  } st_t;

  st_t state_q, state_d;

  logic [7:0]    mem [2**AW];

  logic          x_acc_q, main_cs_q;
  logic [15:0]   x_addr_q;
  logic [AW-1:0] main_addr_q;
  logic          mcu_pend_q, mcu_pend_d;
  logic          main_pend_q, main_pend_d;
  logic          main_ok_q, main_ok_d;
  logic [7:0]    x_din_q, x_din_d;
  logic [7:0]    main_din_q, main_din_d;
  logic [7:0]    m2s_q, m2s_d, s2m_q, s2m_d;
  logic          m2s_full_q, m2s_full_d;
  logic          s2m_full_q, s2m_full_d;

  logic          mcu_req, main_req;
  logic          mcu_hit, main_hit;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wd;
  logic          mcu_rd, mcu_wr, main_rd, main_wr;

`ifdef JTFRAME_8751_MBOX_EN
  assign mcu_hit  = x_addr == MBOX_ADDR;
  assign main_hit = main_mbox;
`else
  logic unused_mbox;
  assign unused_mbox = ^{main_mbox, MBOX_ADDR};
  assign mcu_hit  = 1'b0;
  assign main_hit = 1'b0;
`endif

  assign mcu_req  = x_acc & (~x_acc_q | (x_addr != x_addr_q));
  assign main_req = main_cs & (~main_cs_q |
                    (~main_ok_q & (main_addr != main_addr_q)));

  // A request arriving while its own slot is active stays pending
  assign mcu_pend_d  = mcu_req  | (mcu_pend_q  & (state_q != MCU_ACC));
  assign main_pend_d = main_req | (main_pend_q & (state_q != MAIN_ACC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, MCU_ACC: begin
        if (mcu_pend_d)       state_d = MCU_ACC;
        else if (main_pend_d) state_d = MAIN_ACC;
        else                  state_d = IDLE;
      end
      MAIN_ACC: state_d = MAIN_DONE;
      MAIN_DONE: begin
        if (mcu_pend_d)   state_d = MCU_ACC;
        else if (!main_cs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcu_rd   = (state_q == MCU_ACC) & ~x_wr;
    mcu_wr   = (state_q == MCU_ACC) &  x_wr;
    main_rd  = (state_q == MAIN_ACC) & ~main_we;
    main_wr  = (state_q == MAIN_ACC) &  main_we;
    ram_we   = (mcu_wr & ~mcu_hit) | (main_wr & ~main_hit);
    ram_addr = (state_q == MCU_ACC) ? x_addr[AW-1:0] : main_addr;
    ram_wd   = (state_q == MCU_ACC) ? x_dout : main_dout;
  end

  always_comb begin
    x_din_d    = x_din_q;
    main_din_d = main_din_q;
    m2s_d      = m2s_q;
    s2m_d      = s2m_q;
    m2s_full_d = m2s_full_q;
    s2m_full_d = s2m_full_q;
    main_ok_d  = main_ok_q;
    if (mcu_rd) begin
      x_din_d = mcu_hit ? m2s_q : mem[ram_addr];
      if (mcu_hit) m2s_full_d = 1'b0;
    end
    if (main_rd) begin
      main_din_d = main_hit ? s2m_q : mem[ram_addr];
      if (main_hit) s2m_full_d = 1'b0;
    end
    // Sets come last so they win over a same-cycle clear
    if (mcu_wr && mcu_hit) begin
      s2m_d      = x_dout;
      s2m_full_d = 1'b1;
    end
    if (main_wr && main_hit) begin
      m2s_d      = main_dout;
      m2s_full_d = 1'b1;
    end
    if (!main_cs)                   main_ok_d = 1'b0;
    else if (state_q == MAIN_ACC)   main_ok_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_acc_q     <= 1'b0;
      main_cs_q   <= 1'b0;
      x_addr_q    <= '0;
      main_addr_q <= '0;
      mcu_pend_q  <= 1'b0;
      main_pend_q <= 1'b0;
      main_ok_q   <= 1'b0;
      x_din_q     <= '0;
      main_din_q  <= '0;
      m2s_q       <= '0;
      s2m_q       <= '0;
      m2s_full_q  <= 1'b0;
      s2m_full_q  <= 1'b0;
    end else begin
      x_acc_q     <= x_acc;
      main_cs_q   <= main_cs;
      x_addr_q    <= x_addr;
      main_addr_q <= main_addr;
      mcu_pend_q  <= mcu_pend_d;
      main_pend_q <= main_pend_d;
      main_ok_q   <= main_ok_d;
      x_din_q     <= x_din_d;
      main_din_q  <= main_din_d;
      m2s_q       <= m2s_d;
      s2m_q       <= s2m_d;
      m2s_full_q  <= m2s_full_d;
      s2m_full_q  <= s2m_full_d;
    end
  end

  // Shared RAM: no reset, contents undefined at power-up
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wd;
  end

  assign x_din    = x_din_q;
  assign main_din = main_din_q;
  assign main_ok  = main_ok_q;
  assign mcu_intn = ~m2s_full_q;
  assign main_irq = s2m_full_q;

endmodule

// File: tb/tb_jtframe_8751_xbridge.sv
// Directed bench for jtframe_8751_xbridge (AW=10).
// Mailbox cases run when JTFRAME_8751_MBOX_EN is defined.
module tb_jtframe_8751_xbridge;

  logic        rst, clk;
  logic [15:0] x_addr;
  logic [7:0]  x_dout, x_din;
  logic        x_wr, x_acc;
  logic [9:0]  main_addr;
  logic [7:0]  main_dout, main_din;
  logic        main_we, main_cs, main_mbox;
  logic        main_ok, mcu_intn, main_irq;

  int total = 0;
  int bad   = 0;

  jtframe_8751_xbridge #(.AW(10), .MBOX_ADDR(16'hFFFF)) dut (
    .rst(rst), .clk(clk),
    .x_addr(x_addr), .x_dout(x_dout), .x_wr(x_wr),
    .x_acc(x_acc), .x_din(x_din),
    .main_addr(main_addr), .main_dout(main_dout),
    .main_we(main_we), .main_cs(main_cs),
    .main_mbox(main_mbox), .main_din(main_din),
    .main_ok(main_ok), .mcu_intn(mcu_intn),
    .main_irq(main_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // MCU access; read data checked 3 clk after x_acc rise
  task automatic mcu(input string tag, input logic [15:0] a,
                     input logic wr, input logic [7:0] d);
    @(negedge clk);
    x_addr = a; x_dout = d; x_wr = wr; x_acc = 1'b1;
    tick(3);
    if (!wr) chk(tag, x_din, d);
    tick(1);
    @(negedge clk);
    x_acc = 1'b0; x_wr = 1'b0;
    tick(2);
  endtask

  // Main access; bounded wait for ok, checks hold and release
  task automatic mainx(input string tag, input logic [9:0] a,
                       input logic we, input logic mb,
                       input logic [7:0] d);
    int n;
    @(negedge clk);
    main_addr = a; main_dout = d; main_we = we;
    main_mbox = mb; main_cs = 1'b1;
    n = 0;
    while (!main_ok && n < 10) begin
      tick(1);
      n++;
    end
    chk({tag, "_lat"}, 32'(n <= 4), 1);
    tick(2);
    chk({tag, "_hold"}, main_ok, 1'b1);
    if (!we) chk(tag, main_din, d);
    @(negedge clk);
    main_cs = 1'b0; main_we = 1'b0; main_mbox = 1'b0;
    tick(1);
    chk({tag, "_okdrop"}, main_ok, 1'b0);
    tick(1);
  endtask

  initial begin
    rst = 1'b1;
    x_addr = '0; x_dout = '0; x_wr = 1'b0; x_acc = 1'b0;
    main_addr = '0; main_dout = '0; main_we = 1'b0;
    main_cs = 1'b0; main_mbox = 1'b0;
    tick(3);
    chk("rst_xdin", x_din, 8'h00);
    chk("rst_mdin", main_din, 8'h00);
    chk("rst_ok", main_ok, 1'b0);
    chk("rst_intn", mcu_intn, 1'b1);
    chk("rst_irq", main_irq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);

    // Reset while main_ok high drops it at once
    mainx("pre55", 10'h055, 1'b1, 1'b0, 8'h11);
    @(negedge clk);
    main_addr = 10'h055; main_we = 1'b0; main_cs = 1'b1;
    tick(3);
    chk("ok_before_rst", main_ok, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_async_ok", main_ok, 1'b0);
    @(negedge clk);
    main_cs = 1'b0;
    rst = 1'b0;
    tick(2);

    // Reset mid-MAIN_ACC aborts the write
    @(negedge clk);
    main_addr = 10'h055; main_dout = 8'h99;
    main_we = 1'b1; main_cs = 1'b1;
    tick(1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ok", main_ok, 1'b0);
    chk("rst_mid_intn", mcu_intn, 1'b1);
    chk("rst_mid_irq", main_irq, 1'b0);
    @(negedge clk);
    main_cs = 1'b0; main_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    mainx("nowrite55", 10'h055, 1'b0, 1'b0, 8'h11);

    // Basic MCU write/read and main read
    mcu("mw123", 16'h0123, 1'b1, 8'h5A);
    mcu("mr123", 16'h0123, 1'b0, 8'h5A);
    mainx("main123", 10'h123, 1'b0, 1'b0, 8'h5A);

    // Simultaneous requests: MCU first, main within 4 clk
    mcu("pre010", 16'h0010, 1'b1, 8'h42);
    @(negedge clk);
    x_addr = 16'h0010; x_wr = 1'b0; x_acc = 1'b1;
    main_addr = 10'h010; main_dout = 8'hA5;
    main_we = 1'b1; main_cs = 1'b1;
    tick(3);
    chk("same_xdin", x_din, 8'h42);
    tick(1);
    chk("same_ok4", main_ok, 1'b1);
    @(negedge clk);
    x_acc = 1'b0; main_cs = 1'b0; main_we = 1'b0;
    tick(2);
    mcu("mr010", 16'h0010, 1'b0, 8'hA5);

    // MCU request during main access still within 3 clk
    @(negedge clk);
    main_addr = 10'h010; main_we = 1'b0; main_cs = 1'b1;
    tick(1);
    @(negedge clk);
    x_addr = 16'h0123; x_wr = 1'b0; x_acc = 1'b1;
    tick(3);
    chk("inflight_xdin", x_din, 8'h5A);
    chk("inflight_mdin", main_din, 8'hA5);
    chk("inflight_ok", main_ok, 1'b1);
    // Address change with x_acc held is a new request
    @(negedge clk);
    x_addr = 16'h0010;
    tick(3);
    chk("addrchg_xdin", x_din, 8'hA5);
    chk("ok_held_mcu", main_ok, 1'b1);
    @(negedge clk);
    x_acc = 1'b0; main_cs = 1'b0;
    tick(2);
    chk("ok_release", main_ok, 1'b0);

    // Alias across upper MCU address bits
    mcu("mw8400", 16'h8400, 1'b1, 8'h77);
    mainx("alias000", 10'h000, 1'b0, 1'b0, 8'h77);

`ifdef JTFRAME_8751_MBOX_EN
    mainx("pre3ff", 10'h3FF, 1'b1, 1'b0, 8'h12);
    mainx("m2s_wr", 10'h000, 1'b1, 1'b1, 8'h3C);
    chk("intn_low", mcu_intn, 1'b0);
    mcu("m2s_rd", 16'hFFFF, 1'b0, 8'h3C);
    chk("intn_high", mcu_intn, 1'b1);
    mcu("s2m_wr", 16'hFFFF, 1'b1, 8'hC3);
    chk("irq_high", main_irq, 1'b1);
    mainx("ram3ff_kept", 10'h3FF, 1'b0, 1'b0, 8'h12);
    mainx("s2m_rd", 10'h000, 1'b0, 1'b1, 8'hC3);
    chk("irq_low", main_irq, 1'b0);
`else
    mcu("mwffff", 16'hFFFF, 1'b1, 8'hE1);
    mainx("ram3ff", 10'h3FF, 1'b0, 1'b0, 8'hE1);
    mainx("mbox_ram_wr", 10'h3FE, 1'b1, 1'b1, 8'h66);
    mainx("mbox_ram_rd", 10'h3FE, 1'b0, 1'b0, 8'h66);
    mcu("mrffff", 16'hFFFF, 1'b0, 8'hE1);
    chk("nombox_intn", mcu_intn, 1'b1);
    chk("nombox_irq", main_irq, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
